// File: rtl/vde_pkg.sv
// rtl/vde_pkg.sv - shared constants, types and helpers for the VDE sprite memory
//
// Purpose : common definitions imported by the sprite memory top level.
// Contents: VDE_SPRITE_MEM_LAT  video read latency in cycles
//           VDE_MAX_CH          widest supported channel vector
//           vde_ch_onehot_t     one-hot channel vector (slice to N_CH bits)
//           vde_byte_parity()   even-parity bit of one byte

package vde_pkg;

  localparam int VDE_SPRITE_MEM_LAT = 1;
  localparam int VDE_MAX_CH         = 32;

  // A package type cannot follow a module parameter, so the vector is sized
  // for the widest configuration and users slice the low N_CH bits.
  typedef logic [VDE_MAX_CH-1:0] vde_ch_onehot_t;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic vde_byte_parity(input logic [7:0] b_i);
    return ^b_i;
  endfunction

endpackage

// File: rtl/vde_sprite_mem_mc_if.sv
// rtl/vde_sprite_mem_mc_if.sv - video channel and CPU bus signals of the sprite memory
//
// Purpose : bundles the video read channels and the CPU bus port.
// Modports: slave  - the sprite memory (takes *_i, drives *_o)
//           master - the fetch units / bus interconnect side
// Signals : ch_req_valid_i/ch_req_addr_i/ch_req_ready_o   video requests
//           ch_rsp_valid_o/ch_rsp_data_o/ch_rsp_perr_o    video responses
//           bus_mem_enable_i/wstrb_i/addr_i/wvalue_i      bus access
//           bus_mem_rvalue_o/bus_mem_rvalid_o             bus read return

interface vde_sprite_mem_mc_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int N_CH   = 4
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [N_CH-1:0]        ch_req_valid_i;
  logic [N_CH*ADDR_W-1:0] ch_req_addr_i;
  logic [N_CH-1:0]        ch_req_ready_o;
  logic [N_CH-1:0]        ch_rsp_valid_o;
  logic [DATA_W-1:0]      ch_rsp_data_o;
  logic                   ch_rsp_perr_o;

  logic                   bus_mem_enable_i;
  logic [DATA_W/8-1:0]    bus_mem_wstrb_i;
  logic [ADDR_W-1:0]      bus_mem_addr_i;
  logic [DATA_W-1:0]      bus_mem_wvalue_i;
  logic [DATA_W-1:0]      bus_mem_rvalue_o;
  logic                   bus_mem_rvalid_o;

  modport slave (
    input  ch_req_valid_i, ch_req_addr_i,
    output ch_req_ready_o, ch_rsp_valid_o, ch_rsp_data_o, ch_rsp_perr_o,
    input  bus_mem_enable_i, bus_mem_wstrb_i, bus_mem_addr_i, bus_mem_wvalue_i,
    output bus_mem_rvalue_o, bus_mem_rvalid_o
  );

  modport master (
    output ch_req_valid_i, ch_req_addr_i,
    input  ch_req_ready_o, ch_rsp_valid_o, ch_rsp_data_o, ch_rsp_perr_o,
    output bus_mem_enable_i, bus_mem_wstrb_i, bus_mem_addr_i, bus_mem_wvalue_i,
    input  bus_mem_rvalue_o, bus_mem_rvalid_o
  );

endinterface

// File: rtl/vde_rr_arb.sv
// rtl/vde_rr_arb.sv - round-robin arbiter for the video read channels
//
// Purpose : grants one requesting channel per cycle, searching upward from
//           the round-robin pointer modulo N_CH; owns the pointer.
// Ports   : clk_i, rst_i  clock, async active-high reset
//           valid_i       per-channel request
//           adv_i         a handshake happened this cycle; move the pointer
//           grant_o       one-hot grant (combinational)
//           idx_o         encoded index of the granted channel

module vde_rr_arb #(
  parameter  int N_CH  = 4,
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  valid_i,
  input  logic             adv_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             found;

  // Outer loop walks the search order (pointer first); inner loop keeps all
  // vector indices constant so no variable bit-select is needed.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      for (int j = 0; j < N_CH; j++) begin
        if (!found && valid_i[j] && (j == ((int'(rr_ptr_q) + i) % N_CH))) begin
          found      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv_i) begin
      rr_ptr_d = (idx_o == IDX_W'(N_CH - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/vde_sprite_mem_mc.sv
// rtl/vde_sprite_mem_mc.sv - multi-channel sprite memory with CPU bus port
//
// Purpose : N_CH video fetch channels share one 1-cycle read port through a
//           round-robin arbiter; a second port serves the CPU bus with
//           byte-strobe writes and registered reads.
// Ports   : clk_i   clock
//           rst_i   async active-high reset
//           mem_if  vde_sprite_mem_mc_if.slave (video channels + bus port)
// Build   : VDE_SPRITE_MEM_PARITY_EN adds one even-parity bit per byte,
//           checked on every video read (ch_rsp_perr_o); otherwise
//           ch_rsp_perr_o is tied low.

module vde_sprite_mem_mc
  import vde_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2048,
  parameter  int N_CH   = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  vde_sprite_mem_mc_if.slave mem_if
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  // Storage; never reset, contents survive rst_i.
  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- arbitration ----------------
  logic [N_CH-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             vid_hs;

  assign vid_hs = |(mem_if.ch_req_valid_i & grant);

  vde_rr_arb #(.N_CH(N_CH)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (mem_if.ch_req_valid_i),
    .adv_i   (vid_hs),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign mem_if.ch_req_ready_o = grant;

  // Address of the granted channel.
  logic [ADDR_W-1:0] vid_addr;
  always_comb begin
    vid_addr = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        vid_addr = mem_if.ch_req_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  logic vid_in_range, bus_in_range;
  assign vid_in_range = ({1'b0, vid_addr} < DEPTH_V);
  assign bus_in_range = ({1'b0, mem_if.bus_mem_addr_i} < DEPTH_V);

  // ---------------- bus decode ----------------
  logic bus_wr, bus_rd;
  assign bus_wr = mem_if.bus_mem_enable_i &&  (|mem_if.bus_mem_wstrb_i);
  assign bus_rd = mem_if.bus_mem_enable_i && !(|mem_if.bus_mem_wstrb_i);

  // ---------------- write port ----------------
  // Non-blocking writes give read-first behaviour against the video read
  // below: a same-cycle video read of this address sees the old word.
  always_ff @(posedge clk_i) begin
    if (bus_wr && bus_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_if.bus_mem_wstrb_i[b]) begin
          mem[mem_if.bus_mem_addr_i][8*b +: 8] <= mem_if.bus_mem_wvalue_i[8*b +: 8];
        end
      end
    end
  end

`ifdef VDE_SPRITE_MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  // Only written bytes refresh their parity bit.
  always_ff @(posedge clk_i) begin
    if (bus_wr && bus_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_if.bus_mem_wstrb_i[b]) begin
          par_mem[mem_if.bus_mem_addr_i][b] <= vde_byte_parity(mem_if.bus_mem_wvalue_i[8*b +: 8]);
        end
      end
    end
  end

  logic [NB-1:0] vid_par_calc;
  logic          vid_perr;
  always_comb begin
    vid_par_calc = '0;
    for (int b = 0; b < NB; b++) begin
      vid_par_calc[b] = vde_byte_parity(mem[vid_addr][8*b +: 8]);
    end
    vid_perr = |(vid_par_calc ^ par_mem[vid_addr]);
  end

  logic ch_rsp_perr_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_rsp_perr_q <= 1'b0;
    end else begin
      ch_rsp_perr_q <= vid_hs && vid_in_range && vid_perr;
    end
  end
  assign mem_if.ch_rsp_perr_o = ch_rsp_perr_q;
`else
  assign mem_if.ch_rsp_perr_o = 1'b0;
`endif

  // ---------------- video read port ----------------
  logic [N_CH-1:0]   ch_rsp_valid_q;
  logic [DATA_W-1:0] ch_rsp_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_rsp_valid_q <= '0;
      ch_rsp_data_q  <= '0;
    end else begin
      ch_rsp_valid_q <= vid_hs ? grant : '0;
      if (vid_hs) begin
        ch_rsp_data_q <= vid_in_range ? mem[vid_addr] : '0;
      end
    end
  end

  assign mem_if.ch_rsp_valid_o = ch_rsp_valid_q;
  assign mem_if.ch_rsp_data_o  = ch_rsp_data_q;

  // ---------------- bus read port ----------------
  // rvalue holds its last value whenever rvalid is low.
  logic [DATA_W-1:0] bus_rvalue_q;
  logic              bus_rvalid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_rvalue_q <= '0;
      bus_rvalid_q <= 1'b0;
    end else begin
      bus_rvalid_q <= bus_rd;
      if (bus_rd) begin
        bus_rvalue_q <= bus_in_range ? mem[mem_if.bus_mem_addr_i] : '0;
      end
    end
  end

  assign mem_if.bus_mem_rvalue_o = bus_rvalue_q;
  assign mem_if.bus_mem_rvalid_o = bus_rvalid_q;

endmodule

// File: tb/tb_vde_sprite_mem_mc.sv
// tb/tb_vde_sprite_mem_mc.sv - directed self-checking bench for vde_sprite_mem_mc

module tb_vde_sprite_mem_mc;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2048;
  localparam int N_CH   = 4;
  localparam int AW     = 11;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  vde_sprite_mem_mc_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH)) mem_if ();

  vde_sprite_mem_mc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .mem_if (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive helpers; all are entered and left 1 time unit after a rising edge.
  task automatic set_addr(input int k, input logic [AW-1:0] a);
    mem_if.ch_req_addr_i[k*AW +: AW] = a;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d);
    mem_if.bus_mem_enable_i = 1'b1;
    mem_if.bus_mem_wstrb_i  = s;
    mem_if.bus_mem_addr_i   = a;
    mem_if.bus_mem_wvalue_i = d;
    @(posedge clk); #1;
    mem_if.bus_mem_enable_i = 1'b0;
    mem_if.bus_mem_wstrb_i  = 4'h0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid got=%h exp=0", mem_if.ch_rsp_valid_o); end
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=0", mem_if.ch_rsp_data_o); end
    n_cmp++; if (mem_if.ch_rsp_perr_o !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b exp=0", mem_if.ch_rsp_perr_o); end
    n_cmp++; if (mem_if.bus_mem_rvalue_o !== 32'h0) begin n_err++; $display("FAIL reset_rvalue got=%h exp=0", mem_if.bus_mem_rvalue_o); end
    n_cmp++; if (mem_if.bus_mem_rvalid_o !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", mem_if.bus_mem_rvalid_o); end
    n_cmp++; if (mem_if.ch_req_ready_o !== 4'h0) begin n_err++; $display("FAIL reset_ready got=%h exp=0", mem_if.ch_req_ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_bus_rw;
    bus_write(11'h010, 4'hF, 32'hDEADBEEF);
    n_cmp++; if (mem_if.bus_mem_rvalid_o !== 1'b0) begin n_err++; $display("FAIL write_rvalid got=%b exp=0", mem_if.bus_mem_rvalid_o); end
    mem_if.bus_mem_enable_i = 1'b1;
    mem_if.bus_mem_wstrb_i  = 4'h0;
    mem_if.bus_mem_addr_i   = 11'h010;
    @(posedge clk); #1;
    n_cmp++; if (mem_if.bus_mem_rvalid_o !== 1'b1) begin n_err++; $display("FAIL read_rvalid got=%b exp=1", mem_if.bus_mem_rvalid_o); end
    n_cmp++; if (mem_if.bus_mem_rvalue_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rvalue got=%h exp=deadbeef", mem_if.bus_mem_rvalue_o); end
    mem_if.bus_mem_enable_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_if.bus_mem_rvalid_o !== 1'b0) begin n_err++; $display("FAIL read_rvalid_pulse got=%b exp=0", mem_if.bus_mem_rvalid_o); end
    n_cmp++; if (mem_if.bus_mem_rvalue_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rvalue_hold got=%h exp=deadbeef", mem_if.bus_mem_rvalue_o); end
  endtask

  task automatic test_partial_write;
    bus_write(11'h010, 4'h2, 32'h0000AA00);
    mem_if.ch_req_valid_i = 4'b0001;
    set_addr(0, 11'h010);
    #1;
    n_cmp++; if (mem_if.ch_req_ready_o !== 4'b0001) begin n_err++; $display("FAIL partial_ready got=%b exp=0001", mem_if.ch_req_ready_o); end
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0000;
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'b0001) begin n_err++; $display("FAIL partial_rsp_valid got=%b exp=0001", mem_if.ch_rsp_valid_o); end
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'hDEADAAEF) begin n_err++; $display("FAIL partial_rsp_data got=%h exp=deadaaef", mem_if.ch_rsp_data_o); end
    n_cmp++; if (mem_if.ch_rsp_perr_o !== 1'b0) begin n_err++; $display("FAIL partial_perr got=%b exp=0", mem_if.ch_rsp_perr_o); end
    @(posedge clk); #1;
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'b0000) begin n_err++; $display("FAIL partial_rsp_pulse got=%b exp=0000", mem_if.ch_rsp_valid_o); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    for (int k = 0; k < 4; k++) bus_write(AW'(11'h100 + k), 4'hF, 32'hC0DE0000 + k);
    for (int k = 0; k < 4; k++) set_addr(k, AW'(11'h100 + k));
    // Pointer is 1 after the ch0 access; a lone ch3 access wraps it to 0.
    mem_if.ch_req_valid_i = 4'b1000;
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0000;
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'hC0DE0003) begin n_err++; $display("FAIL rr_pre_data got=%h exp=c0de0003", mem_if.ch_rsp_data_o); end
    mem_if.ch_req_valid_i = 4'b1111;
    #1;
    for (int c = 0; c < 8; c++) begin
      exp_oh = 4'(1 << (c % 4));
      n_cmp++; if (mem_if.ch_req_ready_o !== exp_oh) begin n_err++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, mem_if.ch_req_ready_o, exp_oh); end
      @(posedge clk); #1;
      n_cmp++; if (mem_if.ch_rsp_valid_o !== exp_oh) begin n_err++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=%b", c, mem_if.ch_rsp_valid_o, exp_oh); end
      n_cmp++; if (mem_if.ch_rsp_data_o !== 32'hC0DE0000 + 32'(c % 4)) begin n_err++; $display("FAIL rr_rsp_data[%0d] got=%h exp=%h", c, mem_if.ch_rsp_data_o, 32'hC0DE0000 + 32'(c % 4)); end
    end
    mem_if.ch_req_valid_i = 4'b0000;
    #1;
    n_cmp++; if (mem_if.ch_req_ready_o !== 4'b0000) begin n_err++; $display("FAIL rr_idle_ready got=%b exp=0000", mem_if.ch_req_ready_o); end
    @(posedge clk); #1;
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'b0000) begin n_err++; $display("FAIL rr_idle_rsp got=%b exp=0000", mem_if.ch_rsp_valid_o); end
  endtask

  task automatic test_single_channel;
    // Pointer is 0; a ch2 access moves it to 3.
    mem_if.ch_req_valid_i = 4'b0100;
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0100;
    #1;
    n_cmp++; if (mem_if.ch_req_ready_o !== 4'b0100) begin n_err++; $display("FAIL single_ready got=%b exp=0100", mem_if.ch_req_ready_o); end
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0000;
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'b0100) begin n_err++; $display("FAIL single_rsp_valid got=%b exp=0100", mem_if.ch_rsp_valid_o); end
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'hC0DE0002) begin n_err++; $display("FAIL single_rsp_data got=%h exp=c0de0002", mem_if.ch_rsp_data_o); end
    // Pointer must be 3 now: with everyone requesting, ch3 wins.
    mem_if.ch_req_valid_i = 4'b1111;
    #1;
    n_cmp++; if (mem_if.ch_req_ready_o !== 4'b1000) begin n_err++; $display("FAIL single_ptr_ready got=%b exp=1000", mem_if.ch_req_ready_o); end
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0000;
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'hC0DE0003) begin n_err++; $display("FAIL single_ptr_data got=%h exp=c0de0003", mem_if.ch_rsp_data_o); end
  endtask

  task automatic test_collision;
    bus_write(11'h020, 4'hF, 32'h00000000);
    mem_if.bus_mem_enable_i = 1'b1;
    mem_if.bus_mem_wstrb_i  = 4'hF;
    mem_if.bus_mem_addr_i   = 11'h020;
    mem_if.bus_mem_wvalue_i = 32'h11111111;
    mem_if.ch_req_valid_i   = 4'b0010;
    set_addr(1, 11'h020);
    #1;
    n_cmp++; if (mem_if.ch_req_ready_o !== 4'b0010) begin n_err++; $display("FAIL coll_ready got=%b exp=0010", mem_if.ch_req_ready_o); end
    @(posedge clk); #1;
    mem_if.bus_mem_enable_i = 1'b0;
    mem_if.bus_mem_wstrb_i  = 4'h0;
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'b0010) begin n_err++; $display("FAIL coll_rsp_valid got=%b exp=0010", mem_if.ch_rsp_valid_o); end
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'h00000000) begin n_err++; $display("FAIL coll_old_data got=%h exp=00000000", mem_if.ch_rsp_data_o); end
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0000;
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'b0010) begin n_err++; $display("FAIL coll_b2b_valid got=%b exp=0010", mem_if.ch_rsp_valid_o); end
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'h11111111) begin n_err++; $display("FAIL coll_new_data got=%h exp=11111111", mem_if.ch_rsp_data_o); end
  endtask

  task automatic test_reset_drop;
    mem_if.ch_req_valid_i = 4'b1000;
    set_addr(3, 11'h010);
    #1;
    n_cmp++; if (mem_if.ch_req_ready_o !== 4'b1000) begin n_err++; $display("FAIL drop_ready got=%b exp=1000", mem_if.ch_req_ready_o); end
    @(posedge clk); #1;
    rst = 1'b1;
    mem_if.ch_req_valid_i = 4'b0000;
    @(negedge clk);
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'h0) begin n_err++; $display("FAIL drop_rsp_valid got=%b exp=0000", mem_if.ch_rsp_valid_o); end
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'h0) begin n_err++; $display("FAIL drop_rsp_data got=%h exp=0", mem_if.ch_rsp_data_o); end
    n_cmp++; if (mem_if.ch_rsp_perr_o !== 1'b0) begin n_err++; $display("FAIL drop_perr got=%b exp=0", mem_if.ch_rsp_perr_o); end
    n_cmp++; if (mem_if.bus_mem_rvalue_o !== 32'h0) begin n_err++; $display("FAIL drop_rvalue got=%h exp=0", mem_if.bus_mem_rvalue_o); end
    n_cmp++; if (mem_if.bus_mem_rvalid_o !== 1'b0) begin n_err++; $display("FAIL drop_rvalid got=%b exp=0", mem_if.bus_mem_rvalid_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'h0) begin n_err++; $display("FAIL drop_after_rsp got=%b exp=0000", mem_if.ch_rsp_valid_o); end
    @(posedge clk); #1;
    // Reset returns the pointer to 0.
    mem_if.ch_req_valid_i = 4'b1111;
    #1;
    n_cmp++; if (mem_if.ch_req_ready_o !== 4'b0001) begin n_err++; $display("FAIL drop_ptr_ready got=%b exp=0001", mem_if.ch_req_ready_o); end
    mem_if.ch_req_valid_i = 4'b0000;
    @(posedge clk); #1;
    // Memory contents survive reset.
    mem_if.ch_req_valid_i = 4'b0001;
    set_addr(0, 11'h010);
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0000;
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'hDEADAAEF) begin n_err++; $display("FAIL drop_mem_kept got=%h exp=deadaaef", mem_if.ch_rsp_data_o); end
  endtask

`ifdef VDE_SPRITE_MEM_PARITY_EN
  task automatic test_parity;
    bus_write(11'h030, 4'hF, 32'h12345678);
    dut.par_mem[11'h030][0] = ~dut.par_mem[11'h030][0];
    mem_if.ch_req_valid_i = 4'b0001;
    set_addr(0, 11'h030);
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0000;
    n_cmp++; if (mem_if.ch_rsp_valid_o !== 4'b0001) begin n_err++; $display("FAIL par_rsp_valid got=%b exp=0001", mem_if.ch_rsp_valid_o); end
    n_cmp++; if (mem_if.ch_rsp_perr_o !== 1'b1) begin n_err++; $display("FAIL par_perr_flip got=%b exp=1", mem_if.ch_rsp_perr_o); end
    n_cmp++; if (mem_if.ch_rsp_data_o !== 32'h12345678) begin n_err++; $display("FAIL par_data got=%h exp=12345678", mem_if.ch_rsp_data_o); end
    mem_if.ch_req_valid_i = 4'b0001;
    set_addr(0, 11'h010);
    @(posedge clk); #1;
    mem_if.ch_req_valid_i = 4'b0000;
    n_cmp++; if (mem_if.ch_rsp_perr_o !== 1'b0) begin n_err++; $display("FAIL par_perr_clean got=%b exp=0", mem_if.ch_rsp_perr_o); end
    @(posedge clk); #1;
    n_cmp++; if (mem_if.ch_rsp_perr_o !== 1'b0) begin n_err++; $display("FAIL par_perr_idle got=%b exp=0", mem_if.ch_rsp_perr_o); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    mem_if.ch_req_valid_i   = '0;
    mem_if.ch_req_addr_i    = '0;
    mem_if.bus_mem_enable_i = 1'b0;
    mem_if.bus_mem_wstrb_i  = '0;
    mem_if.bus_mem_addr_i   = '0;
    mem_if.bus_mem_wvalue_i = '0;

    test_reset();
    test_bus_rw();
    test_partial_write();
    test_round_robin();
    test_single_channel();
    test_collision();
    test_reset_drop();
`ifdef VDE_SPRITE_MEM_PARITY_EN
    test_parity();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
